// File: rtl/bsg_manycore_host_credit_gate_pkg.sv
// bsg_manycore_host_credit_gate_pkg: fence states and sizing helpers for the host credit gate
package bsg_manycore_host_credit_gate_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} bsg_host_credit_gate_state_e;

  localparam int bsg_host_credit_gate_timeout_default_gp = 100000;

  function automatic int bsg_host_credit_width(int max_out_credits);
    return $clog2(max_out_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: registered circular FIFO, one read and one write port, enqueue and dequeue allowed together
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p = 4,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rd_r, wr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic enq, deq;

  assign ready_o = cnt_r != cnt_w_lp'(els_p);
  assign v_o = cnt_r != '0;
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;
  assign data_o = mem_r[rd_r];
  assign count_o = cnt_r;

  // pointers wrap at els_p so non-power-of-two depths work
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rd_r <= '0;
      wr_r <= '0;
      cnt_r <= '0;
    end else begin
      if (enq) wr_r <= (wr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_r + 1'b1;
      if (deq) rd_r <= (rd_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_r + 1'b1;
      cnt_r <= cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end

  // storage needs no reset; occupancy alone says what is valid
  always_ff @(posedge clk_i)
    if (enq) mem_r[wr_r] <= data_i;

endmodule

// File: rtl/bsg_manycore_host_credit_gate.sv
// bsg_manycore_host_credit_gate: buffers host requests, launches them under a credit limit, fences until drained (optional BSG_HOST_CREDIT_GATE_TIMEOUT_EN adds a stall timeout)
module bsg_manycore_host_credit_gate
  import bsg_manycore_host_credit_gate_pkg::*;
#(
  parameter int packet_width_p = 128,
  parameter int max_out_credits_p = 16,
  parameter int fifo_els_p = 4,
`ifdef BSG_HOST_CREDIT_GATE_TIMEOUT_EN
  parameter int timeout_cycles_p = bsg_host_credit_gate_timeout_default_gp,
`endif
  localparam int credit_width_lp = bsg_host_credit_width(max_out_credits_p),
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_v_i,
  input  logic [packet_width_p-1:0]  req_packet_i,
  output logic                       req_ready_o,
  output logic                       link_v_o,
  output logic [packet_width_p-1:0]  link_packet_o,
  input  logic                       link_ready_i,
  input  logic                       credit_return_v_i,
  input  logic                       fence_v_i,
  output logic                       fence_busy_o,
  output logic                       fence_done_o,
  output logic [credit_width_lp-1:0] credits_used_o,
  output logic                       underflow_err_o
`ifdef BSG_HOST_CREDIT_GATE_TIMEOUT_EN
  ,
  output logic                       timeout_o
`endif
);

  bsg_host_credit_gate_state_e state_r;
  logic [credit_width_lp-1:0] credits_r, credits_n;
  logic [cnt_w_lp-1:0] count, count_n;
  logic underflow_r, fifo_ready, fifo_v, launch, enq, lone_return;

  bsg_fifo_1r1w_small #(.width_p(packet_width_p), .els_p(fifo_els_p)) buffer (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(req_v_i & req_ready_o),
    .data_i(req_packet_i),
    .ready_o(fifo_ready),
    .v_o(fifo_v),
    .data_o(link_packet_o),
    .yumi_i(launch),
    .count_o(count)
  );

  assign req_ready_o = ~reset_i & fifo_ready & (state_r == IDLE);
  assign enq = req_v_i & req_ready_o;
  assign link_v_o = fifo_v & (credits_r < credit_width_lp'(max_out_credits_p));
  assign launch = link_v_o & link_ready_i;
  assign lone_return = credit_return_v_i & ~launch;
  assign count_n = count + cnt_w_lp'(enq) - cnt_w_lp'(launch);
  assign fence_busy_o = state_r == DRAIN;
  assign fence_done_o = state_r == DONE;
  assign credits_used_o = credits_r;
  assign underflow_err_o = underflow_r;

  // a return with no outstanding credit is dropped rather than wrapping the counter
  always_comb
    credits_n = (launch & ~credit_return_v_i) ? credits_r + 1'b1 :
                (lone_return & credits_r != '0) ? credits_r - 1'b1 : credits_r;

  // credit count, sticky underflow and fence sequencing; drain completion looks at next-cycle occupancy
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      credits_r <= '0;
      underflow_r <= 1'b0;
      state_r <= IDLE;
    end else begin
      credits_r <= credits_n;
      if (lone_return & credits_r == '0) underflow_r <= 1'b1;
      state_r <= (state_r == IDLE) ? (fence_v_i ? DRAIN : IDLE) :
                 (state_r == DRAIN) ? ((count_n == '0 && credits_n == '0) ? DONE : DRAIN) : IDLE;
    end

`ifdef BSG_HOST_CREDIT_GATE_TIMEOUT_EN
  logic [31:0] timer_r, timer_n;
  logic timeout_r;

  assign timer_n = (launch | credit_return_v_i) ? '0 : (credits_r != '0 | fifo_v) ? timer_r + 1 : timer_r;
  assign timeout_o = timeout_r;

  // idle-progress watchdog: any link activity restarts it, pending work advances it
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      timer_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      timer_r <= timer_n;
      if (~timeout_r && timer_n == 32'(timeout_cycles_p)) begin
        timeout_r <= 1'b1;
`ifndef SYNTHESIS
        $display("bsg_manycore_host_credit_gate: no link progress for %0d cycles", timeout_cycles_p);
`endif
      end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_host_credit_gate.sv
// tb_bsg_manycore_host_credit_gate: directed and random checks against a queue-based reference model
module tb_bsg_manycore_host_credit_gate;

  logic clk = 0, reset_i = 1, req_v_i = 0, link_ready_i = 0, credit_return_v_i = 0, fence_v_i = 0;
  logic [127:0] req_packet_i = '0, link_packet_o;
  logic req_ready_o, link_v_o, fence_busy_o, fence_done_o, underflow_err_o;
  logic [4:0] credits_used_o;
  int checks = 0, errors = 0;

  logic [127:0] pq[$];
  int m_cred, m_ph;
  bit m_err;

  bsg_manycore_host_credit_gate dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .req_v_i(req_v_i),
    .req_packet_i(req_packet_i),
    .req_ready_o(req_ready_o),
    .link_v_o(link_v_o),
    .link_packet_o(link_packet_o),
    .link_ready_i(link_ready_i),
    .credit_return_v_i(credit_return_v_i),
    .fence_v_i(fence_v_i),
    .fence_busy_o(fence_busy_o),
    .fence_done_o(fence_done_o),
    .credits_used_o(credits_used_o),
    .underflow_err_o(underflow_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    pq.delete();
    m_cred = 0;
    m_err = 0;
    m_ph = 0;
  endtask

  function automatic bit e_ready();
    return !reset_i && pq.size() < 4 && m_ph == 0;
  endfunction

  function automatic bit e_lv();
    return pq.size() > 0 && m_cred < 16;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".req_ready"}, req_ready_o, e_ready());
    chk({ctx, ".link_v"}, link_v_o, e_lv());
    if (e_lv()) chk({ctx, ".link_packet"}, link_packet_o, pq[0]);
    chk({ctx, ".fence_busy"}, fence_busy_o, m_ph == 1);
    chk({ctx, ".fence_done"}, fence_done_o, m_ph == 2);
    chk({ctx, ".credits"}, credits_used_o, m_cred);
    chk({ctx, ".underflow"}, underflow_err_o, m_err);
  endtask

  task automatic cyc(input string ctx, input bit v, input bit lr, input bit r, input bit f);
    bit acc, launch;
    req_v_i = v;
    req_packet_i = {$urandom, $urandom, $urandom, $urandom};
    link_ready_i = lr;
    credit_return_v_i = r;
    fence_v_i = f;
    @(negedge clk);
    check_all(ctx);
    acc = v && e_ready();
    launch = e_lv() && lr;
    @(posedge clk);
    #1;
    if (launch) void'(pq.pop_front());
    if (acc) pq.push_back(req_packet_i);
    if (launch && !r) m_cred++;
    else if (!launch && r) begin
      if (m_cred == 0) m_err = 1;
      else m_cred--;
    end
    if (m_ph == 0) m_ph = f ? 1 : 0;
    else if (m_ph == 1) m_ph = (pq.size() == 0 && m_cred == 0) ? 2 : 1;
    else m_ph = 0;
  endtask

  initial begin
    mreset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    reset_i = 0;

    for (int i = 0; i < 20; i++) cyc("burst", 1, 1, 0, 0);
    #1;
    chk("burst_credits", credits_used_o, 16);
    chk("burst_link_v", link_v_o, 0);
    chk("burst_ready", req_ready_o, 0);
    chk("burst_buffered", pq.size(), 4);

    cyc("ret1", 0, 1, 1, 0);
    cyc("ret1_launch", 0, 1, 0, 0);
    chk("ret1_credits", credits_used_o, 16);
    chk("ret1_buffered", pq.size(), 3);

    for (int i = 0; i < 11; i++) cyc("retdown", 0, 0, 1, 0);
    chk("at5", credits_used_o, 5);
    cyc("simul", 0, 1, 1, 0);
    chk("simul_credits", credits_used_o, 5);
    chk("simul_err", underflow_err_o, 0);

    for (int i = 0; i < 40 && !(pq.size() == 0 && m_cred == 0); i++) cyc("drainout", 0, 1, m_cred > 0, 0);
    chk("empty_credits", credits_used_o, 0);

    cyc("under", 0, 1, 1, 0);
    chk("under_err", underflow_err_o, 1);
    chk("under_credits", credits_used_o, 0);
    for (int i = 0; i < 3; i++) cyc("pre_fence", i < 3, 1, 0, 0);
    cyc("pre_fence", 0, 1, 0, 0);
    chk("under_sticky", underflow_err_o, 1);
    chk("inflight3", credits_used_o, 3);

    for (int k = 0; k < 14; k++) begin
      chk($sformatf("fence_done_k%0d", k), fence_done_o, k == 10);
      if (k >= 1 && k <= 9) chk($sformatf("fence_busy_k%0d", k), fence_busy_o, 1);
      cyc("fence", k >= 1 && k <= 9, 1, k == 4 || k == 7 || k == 9, k == 0 || k == 5);
    end

    cyc("idle_fence", 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc("idle_fence_tail", 0, 1, m_cred > 0, 0);

    for (int i = 0; i < 400; i++)
      cyc("rand", $urandom % 2 == 1, $urandom_range(0, 3) != 0,
          m_cred > 0 ? ($urandom % 3 == 0) : ($urandom % 20 == 0), $urandom % 25 == 0);
    for (int i = 0; i < 60 && m_ph != 0; i++) cyc("rand_tail", 0, 1, m_cred > 0, 0);
    chk("rand_settled_phase", m_ph, 0);

    cyc("mid_a", 1, 0, 0, 0);
    cyc("mid_b", 1, 0, 0, 0);
    cyc("mid_fence", 0, 0, 0, 1);
    cyc("mid_drain", 0, 0, 0, 0);
    chk("mid_busy", fence_busy_o, 1);
    #3;
    reset_i = 1;
    #1;
    mreset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset_i = 0;
    for (int i = 0; i < 4; i++) cyc("post_reset", 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
